slave_rx_dbuf: RTL and testbench

//  Receiver consuming the master's serial TXout line: deserialises 32-bit frames into two

---
 rtl/slave_rx_dbuf_pkg.sv | 23 ++
 rtl/slave_rx_dbuf_if.sv | 29 ++
 rtl/slave_rx_dbuf_rx_deser.sv | 66 ++++++
 rtl/slave_rx_dbuf.sv | 106 ++++++++++
 tb/tb_slave_rx_dbuf.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/slave_rx_dbuf_pkg.sv
// Shared types and constants for the serial RX double buffer.
// The frame width default is also used by the matching master.
package slave_rx_dbuf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    localparam int ADDR_BUF0 = 0;
    localparam int ADDR_BUF1 = 1;
    localparam int ADDR_STAT = 2;

    localparam int STAT_FULL0 = 0;
    localparam int STAT_FULL1 = 1;
    localparam int STAT_OVR   = 2;
    localparam int STAT_WPTR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } rx_state_e;

endpackage

// File: rtl/slave_rx_dbuf_if.sv
// Serial line plus host read bus for the RX double buffer.
// The master side drives the line and read strobes.
interface slave_rx_dbuf_if
    import slave_rx_dbuf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              RXin;
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataOut;
    logic              RXBuff0;
    logic              RXBuff1;
    logic              frameErr;
    logic              overrun;

    modport master (
        output RXin, read, addr,
        input  dataOut, RXBuff0, RXBuff1,
        input  frameErr, overrun
    );

    modport slave (
        input  RXin, read, addr,
        output dataOut, RXBuff0, RXBuff1,
        output frameErr, overrun
    );
endinterface

// File: rtl/slave_rx_dbuf_rx_deser.sv
// Line deserialiser: start bit, DATA_W bits MSB-first, stop bit.
// frame_valid/frame_err are asserted during the stop-bit cycle.
module slave_rx_dbuf_rx_deser
    import slave_rx_dbuf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic              frame_valid_o,
    output logic              frame_err_o,
    output logic [DATA_W-1:0] frame_o
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        shift_d       = shift_q;
        frame_valid_o = 1'b0;
        frame_err_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_i) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                end
            end
            ST_DATA: begin
                shift_d = {shift_q[DATA_W-2:0], rx_i};
                if (bitcnt_q == LAST) begin
                    state_d = ST_STOP;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                // no resync hunt: a low stop bit just returns to IDLE
                state_d       = ST_IDLE;
                frame_valid_o = rx_i;
                frame_err_o   = !rx_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

    assign frame_o = shift_q;
endmodule

// File: rtl/slave_rx_dbuf.sv
// Serial RX with ping-pong frame buffers and a host read port.
// Reads clear the buffer/overrun flag on the same edge.
module slave_rx_dbuf
    import slave_rx_dbuf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    slave_rx_dbuf_if.slave bus
);
    logic              frame_valid;
    logic              frame_err;
    logic [DATA_W-1:0] frame;

    logic [DATA_W-1:0] bank_q [2];
    logic [DATA_W-1:0] bank_d [2];
    logic [1:0]        full_q, full_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              ovr_q, ovr_d;
    logic              ferr_q, ferr_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              sel0, sel1, sel_st;
    logic [1:0]        clr;
    logic              stat_rd;
    logic [DATA_W-1:0] stat;
    logic [DATA_W-1:0] rdata;

    slave_rx_dbuf_rx_deser #(
        .DATA_W (DATA_W)
    ) u_deser (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_i          (bus.RXin),
        .frame_valid_o (frame_valid),
        .frame_err_o   (frame_err),
        .frame_o       (frame)
    );

    always_comb begin
        sel0    = bus.addr == ADDR_W'(ADDR_BUF0);
        sel1    = bus.addr == ADDR_W'(ADDR_BUF1);
        sel_st  = bus.addr == ADDR_W'(ADDR_STAT);
        clr     = {bus.read && sel1, bus.read && sel0};
        stat_rd = bus.read && sel_st;

        stat             = '0;
        stat[STAT_FULL0] = full_q[0];
        stat[STAT_FULL1] = full_q[1];
        stat[STAT_OVR]   = ovr_q;
        stat[STAT_WPTR]  = wr_ptr_q;

        rdata = '0;
        unique case (1'b1)
            sel0:    rdata = bank_q[0];
            sel1:    rdata = bank_q[1];
            sel_st:  rdata = stat;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        bank_d   = bank_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q & ~clr;
        ovr_d    = stat_rd ? 1'b0 : ovr_q;
        ferr_d   = frame_err;
        dout_d   = bus.read ? rdata : dout_q;
        // a same-edge read clear frees the slot for this commit
        if (frame_valid) begin
            if (full_d[wr_ptr_q]) begin
                ovr_d = 1'b1;
            end else begin
                bank_d[wr_ptr_q] = frame;
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q   <= '{default: '0};
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            bank_q   <= bank_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.dataOut  = dout_q;
    assign bus.RXBuff0  = full_q[0];
    assign bus.RXBuff1  = full_q[1];
    assign bus.frameErr = ferr_q;
    assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_slave_rx_dbuf.sv
// Bench for slave_rx_dbuf: frame-level reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_slave_rx_dbuf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slave_rx_dbuf_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    slave_rx_dbuf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_bank [2];
    logic [1:0]  m_full;
    logic        m_wp;
    logic        m_ovr;
    logic        m_ferr;
    logic [31:0] m_dout;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bank[0] = '0;
        m_bank[1] = '0;
        m_full    = '0;
        m_wp      = 1'b0;
        m_ovr     = 1'b0;
        m_ferr    = 1'b0;
        m_dout    = '0;
    endtask

    // Effect of one clock edge, from the observable rules of the block.
    task automatic model_edge(input logic rd, input logic [3:0] a,
                              input bit commit, input bit err,
                              input logic [31:0] fr);
        logic [31:0] rdata;
        rdata = '0;
        if (a == 4'd0) rdata = m_bank[0];
        else if (a == 4'd1) rdata = m_bank[1];
        else if (a == 4'd2) rdata = {28'd0, m_wp, m_ovr, m_full[1], m_full[0]};
        if (rd) m_dout = rdata;
        if (rd && a == 4'd0) m_full[0] = 1'b0;
        if (rd && a == 4'd1) m_full[1] = 1'b0;
        if (rd && a == 4'd2) m_ovr = 1'b0;
        m_ferr = err;
        if (commit) begin
            if (m_full[m_wp]) begin
                m_ovr = 1'b1;
            end else begin
                m_bank[m_wp] = fr;
                m_full[m_wp] = 1'b1;
                m_wp = ~m_wp;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dataOut", bus.dataOut, m_dout);
            check("RXBuff0", 32'(bus.RXBuff0), 32'(m_full[0]));
            check("RXBuff1", 32'(bus.RXBuff1), 32'(m_full[1]));
            check("frameErr", 32'(bus.frameErr), 32'(m_ferr));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
        end
    end

    task automatic cyc(input logic rx, input logic rd, input logic [3:0] a,
                       input bit commit, input bit err,
                       input logic [31:0] fr);
        bus.RXin = rx;
        bus.read = rd;
        bus.addr = a;
        @(posedge clk);
        model_edge(rd, a, commit, err, fr);
        #1;
        bus.read = 1'b0;
    endtask

    task automatic idle(input logic rd, input logic [3:0] a);
        cyc(1'b1, rd, a, 1'b0, 1'b0, 32'd0);
    endtask

    function automatic logic [3:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(3, 15));
        return 4'($urandom_range(0, 2));
    endfunction

    task automatic send_frame(input logic [31:0] d, input bit stopb,
                              input bit force_rd, input logic [3:0] fa,
                              input bit rnd);
        logic       rx;
        logic       rd;
        logic [3:0] a;
        for (int i = 0; i < 34; i++) begin
            if (i == 0) rx = 1'b0;
            else if (i == 33) rx = stopb;
            else rx = d[32-i];
            rd = 1'b0;
            a  = 4'd0;
            if (rnd && $urandom_range(0, 2) == 0) begin
                rd = 1'b1;
                a  = rnd_addr();
            end
            if (i == 33 && force_rd) begin
                rd = 1'b1;
                a  = fa;
            end
            cyc(rx, rd, a, (i == 33) && stopb, (i == 33) && !stopb, d);
        end
    endtask

    task automatic do_reset();
        bus.RXin = 1'b1;
        bus.read = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.RXin = 1'b1;
        bus.read = 1'b0;
        bus.addr = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", bus.dataOut, 32'd0);
        check("rst_flags", 32'({bus.RXBuff1, bus.RXBuff0}), 32'd0);
        check("rst_err", 32'({bus.frameErr, bus.overrun}), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(1'b0, 4'd0);

        // single frame, then read it back
        send_frame(32'd2, 1'b1, 1'b0, 4'd0, 1'b0);
        check("t1_flag0", 32'(bus.RXBuff0), 32'd1);
        idle(1'b1, 4'd0);
        check("t1_dout", bus.dataOut, 32'd2);
        check("t1_flag0_clr", 32'(bus.RXBuff0), 32'd0);

        // back-to-back frames, then overrun
        do_reset();
        send_frame(32'd2, 1'b1, 1'b0, 4'd0, 1'b0);
        send_frame(32'd8, 1'b1, 1'b0, 4'd0, 1'b0);
        check("t2_flags", 32'({bus.RXBuff1, bus.RXBuff0}), 32'd3);
        idle(1'b1, 4'd2);
        check("t2_stat", bus.dataOut, 32'h3);
        send_frame(32'd67, 1'b1, 1'b0, 4'd0, 1'b0);
        check("t3_ovr", 32'(bus.overrun), 32'd1);
        idle(1'b1, 4'd2);
        check("t3_stat", bus.dataOut, 32'h7);
        check("t3_ovr_clr", 32'(bus.overrun), 32'd0);
        idle(1'b1, 4'd0);
        check("t3_buf0", bus.dataOut, 32'd2);
        idle(1'b1, 4'd1);
        check("t3_buf1", bus.dataOut, 32'd8);

        // bad stop bit
        do_reset();
        send_frame(32'hA5A5_5A5A, 1'b0, 1'b0, 4'd0, 1'b0);
        check("t4_ferr", 32'(bus.frameErr), 32'd1);
        check("t4_flags", 32'({bus.RXBuff1, bus.RXBuff0}), 32'd0);
        idle(1'b0, 4'd0);
        check("t4_ferr_pulse", 32'(bus.frameErr), 32'd0);
        send_frame(32'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        check("t4_recover", 32'(bus.RXBuff0), 32'd1);
        idle(1'b1, 4'd2);
        check("t4_stat", bus.dataOut, 32'h9);

        // reset in the middle of a frame
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_dout", bus.dataOut, 32'd0);
        check("t5_flag0", 32'(bus.RXBuff0), 32'd0);
        check("t5_err", 32'({bus.frameErr, bus.overrun}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0, 4'd0);
        send_frame(32'd3, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(1'b1, 4'd0);
        check("t5_buf0", bus.dataOut, 32'd3);

        // read-clear on the commit edge of the same buffer
        do_reset();
        send_frame(32'd11, 1'b1, 1'b0, 4'd0, 1'b0);
        send_frame(32'd12, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(1'b1, 4'd1);
        send_frame(32'd9, 1'b1, 1'b1, 4'd0, 1'b0);
        check("t6_old", bus.dataOut, 32'd11);
        check("t6_flag0", 32'(bus.RXBuff0), 32'd1);
        idle(1'b1, 4'd0);
        check("t6_new", bus.dataOut, 32'd9);

        // randomized traffic
        do_reset();
        for (int f = 0; f < 80; f++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 0) idle(1'b1, rnd_addr());
                else idle(1'b0, 4'd0);
            end
            send_frame($urandom, $urandom_range(0, 7) != 0, 1'b0, 4'd0,
                       1'b1);
        end
        idle(1'b1, 4'd0);
        idle(1'b1, 4'd1);
        idle(1'b1, 4'd2);
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
